// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM states and the response payload.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Response payload; the rdata field is APB_DATA_W wide, so the bridge's
    // DATA_WIDTH is expected to match APB_DATA_W.
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS wait-state counter; flags the wait cycle that reaches the limit.
module apb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired_c
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign o_expired_c = 1'b0;
        end else begin : g_enabled
            localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] r_cnt;

            // Count wait cycles, clearing on transfer start and stopping at the limit.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt <= '0;
                end else if (i_clr) begin
                    r_cnt <= '0;
                end else if (i_en && (r_cnt != CW'(TIMEOUT_CYCLES))) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            // This wait cycle is the one that brings the count to the limit.
            assign o_expired_c = i_en && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: one valid/ready command in, one APB transfer, one valid/ready response out.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH     = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    PSELx,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    apb_state_e              r_state,   w_state_nxt;
    logic                    r_psel,    w_psel_nxt;
    logic                    r_penable, w_penable_nxt;
    logic                    r_pwrite,  w_pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   r_paddr,   w_paddr_nxt;
    logic [DATA_WIDTH-1:0]   r_pwdata,  w_pwdata_nxt;
    logic [STRB_W-1:0]       r_pstrb,   w_pstrb_nxt;
    logic                    r_rsp_vld, w_rsp_vld_nxt;
    apb_rsp_t                r_rsp,     w_rsp_nxt;
    logic                    w_cnt_clr;
    logic                    w_cnt_en;
    logic                    w_expired;

    assign w_cnt_clr = (r_state == ST_IDLE) && cmd_valid;
    assign w_cnt_en  = (r_state == ST_ACCESS) && !PREADY;

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .i_clk       (PCLK),
        .i_rst_n     (PRESETn),
        .i_clr       (w_cnt_clr),
        .i_en        (w_cnt_en),
        .o_expired_c (w_expired)
    );

    // State and registered APB/response outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= ST_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_rsp_vld <= 1'b0;
            r_rsp     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_pstrb   <= w_pstrb_nxt;
            r_rsp_vld <= w_rsp_vld_nxt;
            r_rsp     <= w_rsp_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless a transition changes it.
    always_comb begin
        w_state_nxt   = r_state;
        w_psel_nxt    = r_psel;
        w_penable_nxt = r_penable;
        w_pwrite_nxt  = r_pwrite;
        w_paddr_nxt   = r_paddr;
        w_pwdata_nxt  = r_pwdata;
        w_pstrb_nxt   = r_pstrb;
        w_rsp_vld_nxt = r_rsp_vld;
        w_rsp_nxt     = r_rsp;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt   = ST_SETUP;
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b0;
                    w_pwrite_nxt  = cmd_write;
                    w_paddr_nxt   = cmd_addr;
                    w_pwdata_nxt  = cmd_write ? cmd_wdata : '0;
                    w_pstrb_nxt   = cmd_write ? cmd_strb  : '0;
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                // PREADY takes priority over a timeout landing in the same cycle.
                if (PREADY) begin
                    w_state_nxt       = ST_RESP;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_vld_nxt     = 1'b1;
                    w_rsp_nxt.rdata   = r_pwrite ? '0 : PRDATA;
                    w_rsp_nxt.err     = PSLVERR;
                    w_rsp_nxt.timeout = 1'b0;
                end else if (w_expired) begin
                    w_state_nxt       = ST_RESP;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_vld_nxt     = 1'b1;
                    w_rsp_nxt.rdata   = '0;
                    w_rsp_nxt.err     = 1'b1;
                    w_rsp_nxt.timeout = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt   = ST_IDLE;
                    w_rsp_vld_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready   = (r_state == ST_IDLE);
    assign PSELx       = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PSTRB       = r_pstrb;
    assign rsp_valid   = r_rsp_vld;
    assign rsp_rdata   = r_rsp.rdata;
    assign rsp_err     = r_rsp.err;
    assign rsp_timeout = r_rsp.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: bench-side completer plus formula-based expectations.
module tb_apb_master_bridge;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic [SW-1:0] PSTRB;

    int n_cmp = 0;
    int n_err = 0;

    apb_master_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSELx       (PSELx),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle_inputs;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
    endtask

    // One complete command: accept, SETUP, ACCESS with `waits` low-PREADY cycles,
    // response held for `rdelay` cycles, then handshake.
    task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input logic [SW-1:0] st, input int waits, input logic [DW-1:0] rd,
                            input logic serr, input int rdelay, input string name);
        logic          exp_to;
        int            exp_pen;
        logic [DW-1:0] exp_rd, exp_wd;
        logic [SW-1:0] exp_st;
        logic          exp_err;
        int            pen;
        exp_to  = (waits >= T);
        exp_pen = exp_to ? T : waits + 1;
        exp_rd  = (wr || exp_to) ? '0 : rd;
        exp_err = exp_to ? 1'b1 : serr;
        exp_wd  = wr ? wd : '0;
        exp_st  = wr ? st : '0;

        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s idle_cmd_ready: got %b exp 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        tick();
        // Scramble command inputs to prove the bridge captured them.
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = AW'($urandom);
        cmd_wdata = $urandom; cmd_strb = SW'($urandom);

        n_cmp++;
        if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, cmd_ready, rsp_valid} !==
            {1'b1, 1'b0, wr, addr, exp_wd, exp_st, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL %s setup: got sel=%b en=%b wr=%b a=%h wd=%h st=%h rdy=%b rv=%b exp sel=1 en=0 wr=%b a=%h wd=%h st=%h rdy=0 rv=0",
                     name, PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, cmd_ready, rsp_valid,
                     wr, addr, exp_wd, exp_st);
        end
        tick();

        pen = 0;
        while (PSELx === 1'b1 && pen < 40) begin
            n_cmp++;
            if ({PENABLE, PWRITE, PADDR, PWDATA, PSTRB} !== {1'b1, wr, addr, exp_wd, exp_st}) begin
                n_err++;
                $display("FAIL %s access_stable cyc%0d: got en=%b wr=%b a=%h wd=%h st=%h exp en=1 wr=%b a=%h wd=%h st=%h",
                         name, pen, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, wr, addr, exp_wd, exp_st);
            end
            PREADY  = (pen == waits);
            PRDATA  = (pen == waits) ? rd : DW'($urandom);
            PSLVERR = (pen == waits) ? serr : 1'($urandom);
            pen++;
            tick();
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = DW'($urandom);

        n_cmp++;
        if (pen !== exp_pen) begin
            n_err++;
            $display("FAIL %s penable_cycles: got %0d exp %0d", name, pen, exp_pen);
        end

        for (int i = 0; i <= rdelay; i++) begin
            n_cmp++;
            if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSELx, PENABLE, cmd_ready} !==
                {1'b1, exp_rd, exp_err, exp_to, 1'b0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL %s resp hold%0d: got rv=%b rd=%h err=%b to=%b sel=%b en=%b rdy=%b exp rv=1 rd=%h err=%b to=%b sel=0 en=0 rdy=0",
                         name, i, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSELx, PENABLE,
                         cmd_ready, exp_rd, exp_err, exp_to);
            end
            if (i < rdelay) begin
                // A pending command must not start a transfer before the handshake.
                cmd_valid = 1'b1;
                tick();
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        n_cmp++;
        if ({rsp_valid, cmd_ready, PSELx, PWRITE, PADDR, PWDATA, PSTRB} !==
            {1'b0, 1'b1, 1'b0, wr, addr, exp_wd, exp_st}) begin
            n_err++;
            $display("FAIL %s after_handshake: got rv=%b rdy=%b sel=%b wr=%b a=%h wd=%h st=%h exp rv=0 rdy=1 sel=0 wr=%b a=%h wd=%h st=%h",
                     name, rsp_valid, cmd_ready, PSELx, PWRITE, PADDR, PWDATA, PSTRB,
                     wr, addr, exp_wd, exp_st);
        end
    endtask

    task automatic test_reset;
        PRESETn = 1'b0;
        idle_inputs();
        #12;
        n_cmp++;
        if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got sel=%b en=%b a=%h wd=%h rv=%b rd=%h err=%b to=%b exp all 0",
                     PSELx, PENABLE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();
        n_cmp++;
        if ({cmd_ready, rsp_valid, PSELx} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b rv=%b sel=%b exp rdy=1 rv=0 sel=0",
                     cmd_ready, rsp_valid, PSELx);
        end
    endtask

    task automatic test_write_zero_wait;
        run_xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 0, "write_zero_wait");
    endtask

    task automatic test_read_wait;
        run_xfer(1'b0, 8'h24, 32'hCAFEF00D, 4'hA, 3, 32'h12345678, 1'b0, 0, "read_3wait");
    endtask

    task automatic test_slverr;
        run_xfer(1'b1, 8'h30, 32'h0BADF00D, 4'h3, 1, 32'h0, 1'b1, 0, "write_slverr");
        run_xfer(1'b0, 8'h34, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 1'b1, 0, "read_slverr");
    endtask

    task automatic test_timeout;
        run_xfer(1'b0, 8'h40, 32'h0, 4'h0, 100, 32'hFFFFFFFF, 1'b0, 0, "timeout_read");
        run_xfer(1'b1, 8'h44, 32'h11223344, 4'hF, T, 32'h0, 1'b1, 0, "timeout_exact");
        run_xfer(1'b0, 8'h48, 32'h0, 4'h0, T - 1, 32'h87654321, 1'b0, 0, "ready_at_limit");
    endtask

    task automatic test_rsp_backpressure;
        run_xfer(1'b0, 8'h50, 32'h0, 4'h0, 2, 32'h5555AAAA, 1'b0, 5, "rsp_backpressure");
    endtask

    task automatic test_reset_mid_access;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h60;
        cmd_wdata = 32'h01020304; cmd_strb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        #3;
        PRESETn = 1'b0;
        #1;
        n_cmp++;
        if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_access: got sel=%b en=%b wr=%b a=%h wd=%h st=%h rv=%b exp all 0",
                     PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();
        n_cmp++;
        if ({cmd_ready, rsp_valid, PSELx, PENABLE} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_mid_release: got rdy=%b rv=%b sel=%b en=%b exp rdy=1 rv=0 sel=0 en=0",
                     cmd_ready, rsp_valid, PSELx, PENABLE);
        end
        run_xfer(1'b0, 8'h64, 32'h0, 4'h0, 1, 32'h600DCAFE, 1'b0, 1, "after_reset");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            run_xfer(1'(i), AW'(8'h70 + i), 32'h100 * i, 4'h1 << i, 0,
                     32'hB0B0_0000 + i, 1'b0, 0, "back_to_back");
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            run_xfer(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                     int'($urandom_range(0, 20)), $urandom, 1'($urandom),
                     int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_rsp_backpressure();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
